register_sequencer: RTL and testbench
=====================================

REGISTER_SEQUENCER -- requirements
Module: register_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of two, >=2).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port cmd_valid  input  1  command offered.
REQ-005 The block SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-006 The block SHALL have port cmd_op  input  3  opcode: 0 NOP, 1 CL, 2 LD, 3 INC, 4 DEC, 5 SR, 6 SL, 7 reserved.
REQ-007 The block SHALL have port cmd_data  input  4  LD value; bit 0 is the shift-in bit for SR and SL.
REQ-008 The block SHALL have port cmd_rep  input  4  repeat count; the op is issued cmd_rep+1 cycles (1..16).
REQ-009 The block SHALL have ports cl, ld, inc, dec, sr, sl  output  1 each  register-stage control strobes.
REQ-010 The block SHALL have ports ir, il  output  1 each  shift-in bits for the register stage.
REQ-011 The block SHALL have port in  output  4  load data for the register stage.
REQ-012 The block SHALL have port busy  output  1  a command is executing or the FIFO is non-empty.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse on the final issue cycle of each command.

Function
REQ-014 cmd_ready SHALL equal !full; a push occurs when cmd_valid && cmd_ready and stores {op, data, rep} at the tail.
REQ-015 When full, cmd_ready SHALL be 0 even if a pop occurs in the same cycle (no push-through-full).
REQ-016 A push and a pop in the same cycle while not full and not empty SHALL leave the occupancy unchanged.
REQ-017 FSM states: IDLE and ISSUE.
REQ-018 IDLE, FIFO non-empty -> pop the head into the execution registers (op, data, remaining=rep), then go to ISSUE.
REQ-019 IDLE, FIFO empty -> stay in IDLE; all strobes SHALL be 0.
REQ-020 All strobe, ir, il, in and done outputs SHALL be registered; the first strobe appears the cycle after the pop.
REQ-021 ISSUE: exactly one strobe SHALL be asserted per cycle, selected by op: CL->cl, LD->ld, INC->inc, DEC->dec, SR->sr, SL->sl.
REQ-022 NOP and reserved op 7 SHALL assert no strobe and SHALL occupy rep+1 wait cycles.
REQ-023 in SHALL equal data during LD cycles and 0 otherwise.
REQ-024 ir SHALL equal data[0] during SR cycles and 0 otherwise; il SHALL equal data[0] during SL cycles and 0 otherwise.
REQ-025 ISSUE with remaining>0 SHALL decrement remaining and stay in ISSUE.
REQ-026 ISSUE with remaining==0 SHALL assert done in that cycle.
REQ-027 On that final cycle, if the FIFO is non-empty, the block SHALL pop the next command so that its first strobe follows with no gap; otherwise it SHALL return to IDLE.
REQ-028 busy SHALL be 1 in ISSUE or when occupancy>0, and 0 otherwise.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be FIFO_DEPTH+1 states wide.

Reset
REQ-030 rst sampled high SHALL, at that edge, force IDLE, flush the FIFO (occupancy 0), clear remaining, and drive every output to 0 except cmd_ready, which goes to 1.
REQ-031 rst asserted mid-command SHALL abort the command; no strobe SHALL be asserted in the cycle after the reset edge.
REQ-032 While rst is high, pushes SHALL be ignored.

Verification
REQ-033 Reset, then push LD data=4'hA rep=0 -> ld=1, in=4'hA, done=1 for exactly one cycle, two cycles after the push edge; busy then 0.
REQ-034 Push INC rep=3 then DEC rep=1 back-to-back -> inc high 4 consecutive cycles, immediately followed by dec high 2 cycles; done pulses on the 4th and 6th strobe cycles.
REQ-035 Hold the FIFO unpopped (long NOP rep=15 executing) and push 4 commands -> cmd_ready=0 after the 4th push; a 5th cmd_valid is not accepted; cmd_ready returns to 1 one cycle after the next pop.
REQ-036 Push SR data=4'h1 rep=1 and SL data=4'h0 rep=0 -> sr=1, ir=1 for 2 cycles, then sl=1, il=0 for 1 cycle; all other strobes stay 0.
REQ-037 Assert rst during the 2nd cycle of INC rep=7 with 2 commands queued -> the next cycle shows all strobes 0, busy=0, cmd_ready=1, and no queued command ever issues.
REQ-038 Push op 7 rep=2 -> 3 cycles with busy=1 and no strobe, then done=1 on the 3rd cycle.

Source files
------------

// File: rtl/register_sequencer.sv
// -----------------------------------------------------------------------------
// register_sequencer
//
// Purpose:
//   Accepts register-stage commands into a small FIFO and replays each one as
//   a train of control strobes towards a downstream shift/load register. Each
//   command names an operation and a repeat count; the operation is issued on
//   rep+1 consecutive cycles. Consecutive queued commands follow each other
//   with no idle cycle in between.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  FIFO can accept a command (not full)
//   cmd_op     in   [2:0] 0 NOP, 1 CL, 2 LD, 3 INC, 4 DEC, 5 SR, 6 SL, 7 reserved
//   cmd_data   in   [3:0] LD value; bit 0 is the shift-in bit for SR/SL
//   cmd_rep    in   [3:0] repeat count, op issued cmd_rep+1 cycles
//   cl..sl     out  registered register-stage control strobes
//   ir, il     out  registered shift-in bits (SR / SL cycles only)
//   in         out  [3:0] registered load data (LD cycles only)
//   busy       out  command in flight, outputs still active, or FIFO non-empty
//   done       out  registered pulse on the final issue cycle of each command
// -----------------------------------------------------------------------------
module register_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [3:0] cmd_rep,
  output logic       cl,
  output logic       ld,
  output logic       inc,
  output logic       dec,
  output logic       sr,
  output logic       sl,
  output logic       ir,
  output logic       il,
  output logic [3:0] in,
  output logic       busy,
  output logic       done
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = 11;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_CL  = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_DEC = 3'd4;
  localparam logic [2:0] OP_SR  = 3'd5;
  localparam logic [2:0] OP_SL  = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // One-hot strobe pattern {cl, ld, inc, dec, sr, sl} for an opcode; NOP and
  // the reserved opcode map to no strobe at all.
  function automatic logic [5:0] op_strobes(input logic [2:0] op);
    logic [5:0] s;
    case (op)
      OP_CL:   s = 6'b100000;
      OP_LD:   s = 6'b010000;
      OP_INC:  s = 6'b001000;
      OP_DEC:  s = 6'b000100;
      OP_SR:   s = 6'b000010;
      OP_SL:   s = 6'b000001;
      OP_NOP:  s = 6'b000000;
      default: s = 6'b000000;
    endcase
    return s;
  endfunction

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Execution registers for the command currently being issued
  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [3:0]         data_q, data_d;
  logic [3:0]         rem_q, rem_d;

  // Registered output stage
  logic [5:0]         strobe_q, strobe_d;
  logic               ir_q, ir_d;
  logic               il_q, il_d;
  logic [3:0]         in_q, in_d;
  logic               done_q, done_d;
  logic               act_q, act_d;

  logic               empty_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic               issue_s;
  logic               last_s;
  logic [ENTRY_W-1:0] head_s;

  assign empty_s   = (count_q == CNT_ZERO);
  assign full_s    = (count_q == DEPTH_C);
  assign cmd_ready = !full_s;
  // Pushes are qualified with rst so nothing is stored while reset is held.
  assign push_s    = cmd_valid && !full_s && !rst;
  assign head_s    = fifo_mem_q[rd_ptr_q];

  // Next-state logic for the sequencer FSM, the execution registers and the
  // registered output stage.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    pop_s   = 1'b0;
    issue_s = 1'b0;
    last_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          op_d    = head_s[10:8];
          data_d  = head_s[7:4];
          rem_d   = head_s[3:0];
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issue_s = 1'b1;
        if (rem_q != 4'd0) begin
          rem_d   = rem_q - 4'd1;
          state_d = ST_ISSUE;
        end else begin
          last_s = 1'b1;
          // Chain straight into the next queued command so its first strobe
          // lands on the cycle right after this command's done.
          if (!empty_s) begin
            pop_s   = 1'b1;
            op_d    = head_s[10:8];
            data_d  = head_s[7:4];
            rem_d   = head_s[3:0];
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output stage follows the executing op by one register.
    if (issue_s) begin
      strobe_d = op_strobes(op_q);
    end else begin
      strobe_d = 6'b000000;
    end

    if (issue_s && (op_q == OP_LD)) begin
      in_d = data_q;
    end else begin
      in_d = 4'd0;
    end

    if (issue_s && (op_q == OP_SR)) begin
      ir_d = data_q[0];
    end else begin
      ir_d = 1'b0;
    end

    if (issue_s && (op_q == OP_SL)) begin
      il_d = data_q[0];
    end else begin
      il_d = 1'b0;
    end

    done_d = last_s;
    act_d  = issue_s;
  end

  // Next-state logic for the FIFO pointers and occupancy.
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO pointers, occupancy, execution registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      op_q     <= OP_NOP;
      data_q   <= 4'd0;
      rem_q    <= 4'd0;
      strobe_q <= 6'b000000;
      ir_q     <= 1'b0;
      il_q     <= 1'b0;
      in_q     <= 4'd0;
      done_q   <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      op_q     <= op_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      strobe_q <= strobe_d;
      ir_q     <= ir_d;
      il_q     <= il_d;
      in_q     <= in_d;
      done_q   <= done_d;
      act_q    <= act_d;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {cmd_op, cmd_data, cmd_rep};
    end
  end

  assign {cl, ld, inc, dec, sr, sl} = strobe_q;
  assign ir   = ir_q;
  assign il   = il_q;
  assign in   = in_q;
  assign done = done_q;
  // act_q keeps busy high while the last issued cycle is still on the outputs.
  assign busy = (state_q == ST_ISSUE) || !empty_s || act_q;

endmodule

// File: tb/tb_register_sequencer.sv
// -----------------------------------------------------------------------------
// tb_register_sequencer
//
// Directed self-checking bench. Stimulus lives in one initial block and acts
// 2 time units after each rising edge. Every pushed command appends its
// expected per-cycle output vectors {cl,ld,inc,dec,sr,sl,ir,il,in,done} to a
// scoreboard queue; a monitor on the falling edge pops one entry per cycle and
// compares, or expects all-quiet outputs when the queue is empty.
// -----------------------------------------------------------------------------
module tb_register_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_rep;
  logic       cl, ld, inc, dec, sr, sl, ir, il;
  logic [3:0] in_s;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic        chk_busy;
    logic [12:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  always #5 clk = ~clk;

  register_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_rep   (cmd_rep),
    .cl        (cl),
    .ld        (ld),
    .inc       (inc),
    .dec       (dec),
    .sr        (sr),
    .sl        (sl),
    .ir        (ir),
    .il        (il),
    .in        (in_s),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [12:0] obs_vec();
    return {cl, ld, inc, dec, sr, sl, ir, il, in_s, done};
  endfunction

  // Expected output vector for one issue cycle of a command.
  function automatic logic [12:0] model_vec(input logic [2:0] op, input logic [3:0] data,
                                            input bit last);
    logic [5:0] s    = 6'd0;
    logic       ir_e = 1'b0;
    logic       il_e = 1'b0;
    logic [3:0] in_e = 4'd0;
    case (op)
      3'd1: s[5] = 1'b1;
      3'd2: begin s[4] = 1'b1; in_e = data; end
      3'd3: s[3] = 1'b1;
      3'd4: s[2] = 1'b1;
      3'd5: begin s[1] = 1'b1; ir_e = data[0]; end
      3'd6: begin s[0] = 1'b1; il_e = data[0]; end
      default: s = 6'd0;
    endcase
    return {s, ir_e, il_e, in_e, last};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: one entry per cycle, quiet outputs when empty.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("outputs", 32'(obs_vec()), 32'(e.vec));
        if (e.chk_busy) check("busy_active", 32'(busy), 32'd1);
      end else begin
        check("idle_outputs", 32'(obs_vec()), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Push one command; gaps = quiet cycles before its first strobe is seen.
  task automatic push_cmd(input logic [2:0] op, input logic [3:0] data,
                          input logic [3:0] rep, input int gaps);
    check("ready_before_push", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_data  = data;
    cmd_rep   = rep;
    cmd_valid = 1'b1;
    for (int g = 0; g < gaps; g++) sb_q.push_back('{1'b0, 13'd0});
    for (int i = 0; i <= int'(rep); i++)
      sb_q.push_back('{1'b1, model_vec(op, data, i == int'(rep))});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() > 0 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_drain_timeout"}, 32'(n < 400), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'd0;
    cmd_rep   = 4'd0;
    repeat (3) tick();
    check("reset_outputs", 32'(obs_vec()), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single LD, rep 0
    push_cmd(3'd2, 4'hA, 4'd0, 3);
    drain("ld_single");

    // INC x4 then DEC x2, back to back
    push_cmd(3'd3, 4'h0, 4'd3, 3);
    push_cmd(3'd4, 4'h0, 4'd1, 0);
    drain("inc_dec");

    // Fill the FIFO behind a long NOP
    push_cmd(3'd0, 4'h0, 4'd15, 3);
    push_cmd(3'd2, 4'h3, 4'd0, 0);
    push_cmd(3'd3, 4'h0, 4'd1, 0);
    push_cmd(3'd5, 4'h1, 4'd0, 0);
    push_cmd(3'd4, 4'h0, 4'd0, 0);
    check("full_ready_low", 32'(cmd_ready), 32'd0);
    cmd_op    = 3'd1;
    cmd_data  = 4'h0;
    cmd_rep   = 4'd0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("full_hold_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_return_cycle", 32'(n), 32'd8);
    drain("fifo_full");

    // SR with shift-in 1, then SL with shift-in 0
    push_cmd(3'd5, 4'h1, 4'd1, 3);
    push_cmd(3'd6, 4'h0, 4'd0, 0);
    drain("shift");

    // Reserved opcode behaves as a wait
    push_cmd(3'd7, 4'hF, 4'd2, 3);
    drain("reserved_op");

    // Reset in the 2nd INC cycle with two commands queued
    push_cmd(3'd3, 4'h0, 4'd7, 3);
    push_cmd(3'd1, 4'h0, 4'd0, 0);
    push_cmd(3'd2, 4'h5, 4'd0, 0);
    tick();
    rst       = 1'b1;
    cmd_op    = 3'd1;
    cmd_rep   = 4'd0;
    cmd_valid = 1'b1;
    tick();
    sb_q.delete();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    check("abort_outputs", 32'(obs_vec()), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (12) tick();
    check("abort_busy_later", 32'(busy), 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
